// File: rtl/mul_div_unit.sv
// mul_div_unit: sequential RV32M/RV64M multiply/divide unit beside the ALU; build flag MUL_FAST_EN selects a single-cycle multiplier.
// Latency: out_valid XLEN+1 cycles after accept for iterative ops; 1 cycle for divide special cases (and multiplies with MUL_FAST_EN).
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE, so requests stall and are not sampled.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_op;
    logic            r_sa, r_sb;
    logic [XLEN-1:0] r_hi, r_lo, r_opb, r_result;
    logic [CW-1:0]   r_cnt;

    // Sign fix-up of a magnitude result. hi/lo hold the product halves, or remainder/quotient for divides.
    function automatic logic [XLEN-1:0] f_finalize(input logic [2:0] f_op, input logic f_sa,
                                                   input logic f_sb, input logic [XLEN-1:0] f_hi,
                                                   input logic [XLEN-1:0] f_lo);
        logic [2*XLEN-1:0] p;
        p = {f_hi, f_lo};
        if (f_sa ^ f_sb) p = -p;
        case (f_op)
            3'b000:  return f_lo;
            3'b100:  return (f_sa ^ f_sb) ? -f_lo : f_lo;
            3'b101:  return f_lo;
            3'b110:  return f_sa ? -f_hi : f_hi;
            3'b111:  return f_hi;
            default: return p[2*XLEN-1:XLEN];
        endcase
    endfunction

    logic            w_accept, w_is_div, w_sa, w_sb, w_special, w_direct;
    logic [XLEN-1:0] w_ma, w_mb, w_special_res, w_direct_res, w_hi_nxt, w_lo_nxt;
    logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_diff;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_is_div  = op[2];
    assign w_sa      = a[XLEN-1] && ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110));
    assign w_sb      = b[XLEN-1] && ((op == 3'b001) || (op == 3'b100) || (op == 3'b110));
    assign w_ma      = w_sa ? -a : a;
    assign w_mb      = w_sb ? -b : b;

    // Divide by zero and signed overflow bypass the iteration entirely.
    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (w_is_div && (b == '0)) begin
            w_special     = 1'b1;
            w_special_res = op[1] ? a : '1;
        end else if (((op == 3'b100) || (op == 3'b110)) && (a == MIN_INT) && (b == '1)) begin
            w_special     = 1'b1;
            w_special_res = op[1] ? '0 : MIN_INT;
        end
    end

`ifdef MUL_FAST_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod  = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
    assign w_direct     = w_special || !w_is_div;
    assign w_direct_res = w_special ? w_special_res
                        : f_finalize(op, w_sa, w_sb, w_fast_prod[2*XLEN-1:XLEN], w_fast_prod[XLEN-1:0]);
`else
    assign w_direct     = w_special;
    assign w_direct_res = w_special_res;
`endif

    // One iteration step: shift-add multiply (multiplier in lo) or restoring divide (dividend shifting out of lo).
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};

    // Select the next hi/lo pair for the operation in flight.
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op[2]) begin
            if (!w_div_diff[XLEN]) begin
                w_hi_nxt = w_div_diff[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_div_shift[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {w_hi_nxt, w_lo_nxt} = {w_mul_sum, r_lo[XLEN-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) w_state_nxt = w_direct ? S_DONE : S_CALC;
            end
            S_CALC: if (r_cnt <= CW'(1)) w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_op  <= op;
                r_sa  <= w_sa;
                r_sb  <= w_sb;
                r_cnt <= CW'(XLEN);
                r_hi  <= '0;
                r_lo  <= w_is_div ? w_ma : w_mb;
                r_opb <= w_is_div ? w_mb : w_ma;
                if (w_direct) r_result <= w_direct_res;
            end
        end else if (r_state == S_CALC) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) r_result <= f_finalize(r_op, r_sa, r_sb, w_hi_nxt, w_lo_nxt);
        end
    end

    assign result = r_result;

endmodule
